// File: rtl/dft_compute_fadd_driver_pkg.sv
// Shared float field layout and default sizing for the fadd driver slice.
// No logic: widths, packed float type, default adder latency and result FIFO depth.
// Imported by the interface, the result FIFO and the driver top.
package dft_fadd_pkg;

    localparam int FP_EXP_W = 8;
    localparam int FP_MAN_W = 23;
    localparam int FP_W     = 32;

    typedef struct packed {
        logic                sign;
        logic [FP_EXP_W-1:0] exp;
        logic [FP_MAN_W-1:0] man;
    } fp32_t;

    localparam int DEF_LAT   = 1;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/dft_compute_fadd_driver_if.sv
// Operand/result bundle between the environment (master) and the fadd driver (slave).
// Carries the issue handshake, unpacked operands, adder hold/return, and result handshake.
// Backpressure: in_ready/astall toward the source, out_ready from the sink.
interface dft_compute_fadd_driver_if;
    import dft_fadd_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [FP_W-1:0]     in_a;
    logic [FP_W-1:0]     in_b;
    logic                a_sign;
    logic [FP_EXP_W-1:0] a_exp;
    logic [FP_MAN_W-1:0] a_man;
    logic                b_sign;
    logic [FP_EXP_W-1:0] b_exp;
    logic [FP_MAN_W-1:0] b_man;
    logic                astall;
    logic [FP_W-1:0]     x;
    logic                out_valid;
    logic                out_ready;
    logic [FP_W-1:0]     out_data;

    modport master (
        output in_valid, in_a, in_b, x, out_ready,
        input  in_ready, a_sign, a_exp, a_man, b_sign, b_exp, b_man,
               astall, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_a, in_b, x, out_ready,
        output in_ready, a_sign, a_exp, a_man, b_sign, b_exp, b_man,
               astall, out_valid, out_data
    );

endinterface

// File: rtl/dft_fadd_res_fifo.sv
// Synchronous DEPTH x W result FIFO with occupancy count and registered head.
// Latency: a push is visible at the head on the next cycle.
// Backpressure: push while full and pop while empty are ignored.
module dft_fadd_res_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          arst_n,
    input  logic          i_push,
    input  logic [W-1:0]  i_push_dat,
    input  logic          i_pop,
    output logic          o_vld,
    output logic [W-1:0]  o_dat,
    output logic [CW-1:0] o_cnt
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_push = i_push & (r_cnt != CW'(DEPTH));
    assign w_pop  = i_pop & (r_cnt != '0);

    assign o_vld = (r_cnt != '0);
    assign o_dat = r_mem[r_rptr];
    assign o_cnt = r_cnt;

    // Storage is deliberately left out of reset; only pointers and count are cleared.
    always_ff @(posedge aclk) begin
        if (w_push) r_mem[r_wptr] <= i_push_dat;
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
            if (w_pop)  r_rptr <= (r_rptr == PW'(DEPTH - 1)) ? '0 : r_rptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CW'(1);
                2'b01:   r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/dft_compute_fadd_driver.sv
// Drives an external LAT-cycle float adder and queues its sums in issue order (DFT_FADD_DRV_STATS_EN adds counters).
// Latency: issue to out_valid is LAT+1 cycles without stall.
// Backpressure: astall (= ~in_ready) holds the adder whenever queued + in-flight results could fill the FIFO.
module dft_compute_fadd_driver
    import dft_fadd_pkg::*;
#(
    parameter int LAT   = DEF_LAT,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     aclk,
    input  logic                     arst_n,
`ifdef DFT_FADD_DRV_STATS_EN
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_stall,
`endif
    dft_compute_fadd_driver_if.slave bus
);

    localparam int           CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]  OCC_LIM = (CW + 1)'(DEPTH);

    fp32_t          w_a;
    fp32_t          w_b;
    logic [LAT-1:0] r_vld;
    logic [CW-1:0]  w_cnt;
    logic [CW-1:0]  w_inflight;
    logic [CW:0]    w_occ;
    logic           w_astall;
    logic           w_issue;
    logic           w_retire;
    logic           w_out_vld;
    logic           w_pop;

    assign w_a = fp32_t'(bus.in_a);
    assign w_b = fp32_t'(bus.in_b);

    // Fields go out every cycle; only r_vld decides whether a slot carries a real op.
    assign bus.a_sign = w_a.sign;
    assign bus.a_exp  = w_a.exp;
    assign bus.a_man  = w_a.man;
    assign bus.b_sign = w_b.sign;
    assign bus.b_exp  = w_b.exp;
    assign bus.b_man  = w_b.man;

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            w_inflight = w_inflight + CW'(r_vld[i]);
        end
    end

    // Credit check from registered state only, so a pop frees space one cycle later.
    assign w_occ    = {1'b0, w_cnt} + {1'b0, w_inflight};
    assign w_astall = (w_occ >= OCC_LIM);

    assign bus.astall   = w_astall;
    assign bus.in_ready = ~w_astall;

    assign w_issue  = bus.in_valid & ~w_astall;
    assign w_retire = r_vld[LAT-1] & ~w_astall;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_vld <= '0;
        end else if (!w_astall) begin
            r_vld <= (r_vld << 1) | LAT'(w_issue);
        end
    end

    dft_fadd_res_fifo #(
        .DEPTH (DEPTH),
        .W     (FP_W)
    ) u_fifo (
        .aclk       (aclk),
        .arst_n     (arst_n),
        .i_push     (w_retire),
        .i_push_dat (bus.x),
        .i_pop      (w_pop),
        .o_vld      (w_out_vld),
        .o_dat      (bus.out_data),
        .o_cnt      (w_cnt)
    );

    assign bus.out_valid = w_out_vld;
    assign w_pop         = w_out_vld & bus.out_ready;

`ifdef DFT_FADD_DRV_STATS_EN
    logic [31:0] r_stat_ops;
    logic [31:0] r_stat_stall;

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            r_stat_ops   <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_pop)    r_stat_ops   <= r_stat_ops + 32'd1;
            if (w_astall) r_stat_stall <= r_stat_stall + 32'd1;
        end
    end

    assign stat_ops   = r_stat_ops;
    assign stat_stall = r_stat_stall;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dft_compute_fadd_driver.sv
// Directed bench for dft_compute_fadd_driver with a behavioural LAT-stage adder honouring astall.
// Vector table of {a, b, sum}, plus sequences for backpressure, occupancy, reset and stats.
module tb_dft_compute_fadd_driver;

    localparam int LAT   = 1;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
    } vec_t;

    logic aclk = 1'b0;
    logic arst_n;

    dft_compute_fadd_driver_if bus();

`ifdef DFT_FADD_DRV_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_stall;
`endif

    dft_compute_fadd_driver #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .aclk       (aclk),
        .arst_n     (arst_n),
`ifdef DFT_FADD_DRV_STATS_EN
        .stat_ops   (stat_ops),
        .stat_stall (stat_stall),
`endif
        .bus        (bus)
    );

    always #5 aclk = ~aclk;

    // Positive-normal float add (align, add, one-step normalise, truncate).
    function automatic logic [31:0] fadd_pos(input logic [31:0] p, input logic [31:0] q);
        logic [7:0]  ep;
        logic [7:0]  eq;
        logic [7:0]  eb;
        logic [24:0] mp;
        logic [24:0] mq;
        logic [24:0] ms;
        ep = p[30:23];
        eq = q[30:23];
        mp = {2'b01, p[22:0]};
        mq = {2'b01, q[22:0]};
        if (ep >= eq) begin
            eb = ep;
            mq = mq >> (ep - eq);
        end else begin
            eb = eq;
            mp = mp >> (eq - ep);
        end
        ms = mp + mq;
        if (ms[24]) begin
            ms = ms >> 1;
            eb = eb + 8'd1;
        end
        return {p[31], eb, ms[22:0]};
    endfunction

    logic [31:0] pipe [LAT];

    always @(posedge aclk) begin
        if (!bus.astall) begin
            pipe[0] <= fadd_pos({bus.a_sign, bus.a_exp, bus.a_man}, {bus.b_sign, bus.b_exp, bus.b_man});
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign bus.x = pipe[LAT-1];

    int          n_chk;
    int          n_pass;
    int          cyc;
    int          n_iss;
    int          n_pop;
    int          n_stall_obs;
    int          n_rdy_drop;
    bit          feed;
    vec_t        vt [8];
    vec_t        pend_q [$];
    logic [31:0] exp_q [$];
    int          iss_q [$];
    int          pop_q [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, req);
    endtask

    // One clock: present the next pending op, observe at negedge, return at posedge+1.
    task automatic tick();
        if (feed && pend_q.size() != 0) begin
            bus.in_valid = 1'b1;
            bus.in_a     = pend_q[0].a;
            bus.in_b     = pend_q[0].b;
        end else begin
            bus.in_valid = 1'b0;
        end
        @(negedge aclk);
        if (arst_n) begin
            if (bus.astall) n_stall_obs++;
            if (bus.in_valid && !bus.in_ready) n_rdy_drop++;
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(pend_q[0].s);
                void'(pend_q.pop_front());
                iss_q.push_back(cyc);
                n_iss++;
            end
            if (bus.out_valid && bus.out_ready) begin
                pop_q.push_back(cyc);
                n_pop++;
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_output: got %h, want no result", bus.out_data);
                end else begin
                    chk("out_data", bus.out_data, exp_q.pop_front());
                end
            end
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic clear_obs();
        n_iss = 0;
        n_pop = 0;
        n_rdy_drop = 0;
        n_stall_obs = 0;
        iss_q.delete();
        pop_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{32'h3F800000, 32'h40000000, 32'h40400000};
        vt[1] = '{32'h3F800000, 32'h3F800000, 32'h40000000};
        vt[2] = '{32'h40000000, 32'h40000000, 32'h40800000};
        vt[3] = '{32'h3FC00000, 32'h3FC00000, 32'h40400000};
        vt[4] = '{32'h3F000000, 32'h3E800000, 32'h3F400000};
        vt[5] = '{32'h40400000, 32'h3F800000, 32'h40800000};
        vt[6] = '{32'h40800000, 32'h40800000, 32'h41000000};
        vt[7] = '{32'h3F800000, 32'h3F000000, 32'h3FC00000};

        n_chk = 0; n_pass = 0; cyc = 0; feed = 1'b0;
        clear_obs();
        arst_n        = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_astall", 32'(bus.astall), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        arst_n = 1'b1;

        // Unpack with in_valid low
        bus.in_a = 32'hC0490FDB;
        bus.in_b = 32'h3F800000;
        #1;
        chk("a_sign", 32'(bus.a_sign), 32'd1);
        chk("a_exp", 32'(bus.a_exp), 32'h80);
        chk("a_man", 32'(bus.a_man), 32'h490FDB);
        chk("b_sign", 32'(bus.b_sign), 32'd0);
        chk("b_exp", 32'(bus.b_exp), 32'h7F);
        chk("b_man", 32'(bus.b_man), 32'h0);
        tick();

        // Single op latency
        clear_obs();
        bus.out_ready = 1'b1;
        pend_q.push_back(vt[0]);
        feed = 1'b1;
        for (int k = 0; k < 20 && n_pop < 1; k++) tick();
        chk("single_done", 32'(n_pop), 32'd1);
        if (n_pop >= 1 && n_iss >= 1) chk("single_latency", 32'(pop_q[0] - iss_q[0]), 32'(LAT + 1));
        repeat (3) tick();

        // Back-to-back table
        clear_obs();
        for (int v = 0; v < 8; v++) pend_q.push_back(vt[v]);
        for (int k = 0; k < 60 && n_pop < 8; k++) tick();
        chk("b2b_pops", 32'(n_pop), 32'd8);
        chk("b2b_ready_drop", 32'(n_rdy_drop), 32'd0);
        for (int k = 1; k < pop_q.size(); k++) chk("b2b_gap", 32'(pop_q[k] - pop_q[k-1]), 32'd1);
        repeat (3) tick();

        // Backpressure then drain
        clear_obs();
        bus.out_ready = 1'b0;
        for (int v = 0; v < 6; v++) pend_q.push_back(vt[v]);
        repeat (DEPTH + LAT + 4) tick();
        chk("bp_issued", 32'(n_iss), 32'(DEPTH));
        chk("bp_astall", 32'(bus.astall), 32'd1);
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40 && n_pop < 6; k++) tick();
        repeat (4) tick();
        chk("bp_pops", 32'(n_pop), 32'd6);
        chk("bp_left", 32'(exp_q.size()), 32'd0);

        // Steady push+pop at occupancy DEPTH-1
        clear_obs();
        bus.out_ready = 1'b0;
        for (int v = 0; v < 7; v++) pend_q.push_back(vt[v]);
        repeat (3) tick();
        chk("occ_pre", 32'(dut.w_cnt) + 32'(dut.w_inflight), 32'(DEPTH - 1));
        bus.out_ready = 1'b1;
        repeat (4) begin
            tick();
            chk("occ_hold", 32'(dut.w_cnt) + 32'(dut.w_inflight), 32'(DEPTH - 1));
            chk("occ_astall", 32'(bus.astall), 32'd0);
        end
        for (int k = 0; k < 40 && (exp_q.size() != 0 || pend_q.size() != 0); k++) tick();
        repeat (3) tick();
        chk("occ_pops", 32'(n_pop), 32'd7);

        // Reset with results queued and in flight
        clear_obs();
        bus.out_ready = 1'b0;
        for (int v = 0; v < 6; v++) pend_q.push_back(vt[v]);
        repeat (DEPTH + LAT + 2) tick();
        #2;
        arst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_astall", 32'(bus.astall), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        feed = 1'b0;
        pend_q.delete();
        exp_q.delete();
        repeat (2) tick();
        arst_n = 1'b1;
        clear_obs();
        bus.out_ready = 1'b1;
        pend_q.push_back(vt[4]);
        feed = 1'b1;
        for (int k = 0; k < 20 && n_pop < 1; k++) tick();
        repeat (4) tick();
        chk("post_rst_pops", 32'(n_pop), 32'd1);

`ifdef DFT_FADD_DRV_STATS_EN
        arst_n = 1'b0;
        repeat (2) tick();
        arst_n = 1'b1;
        chk("stat_ops_rst", stat_ops, 32'd0);
        chk("stat_stall_rst", stat_stall, 32'd0);
        clear_obs();
        bus.out_ready = 1'b0;
        for (int v = 0; v < 10; v++) pend_q.push_back(vt[v % 8]);
        for (int k = 0; k < 40 && !bus.out_ready; k++) begin
            if (bus.astall && n_stall_obs == 3) bus.out_ready = 1'b1;
            tick();
        end
        for (int k = 0; k < 60 && (exp_q.size() != 0 || pend_q.size() != 0); k++) tick();
        repeat (3) tick();
        chk("stat_ops", stat_ops, 32'd10);
        chk("stat_stall", stat_stall, 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
